esp32_boot_sequencer: RTL and testbench
=======================================

Name: esp32_boot_sequencer

Overview:
FPGA-side initiator that drives the ESP32 into download mode or normal boot with a timed EN/strap sequence. It replaces the host's DTR/RTS toggling, so on-board logic (e.g. a flash loader) can reboot the ESP32 without a USB host.
Outputs are open-drain style controls (drive enables plus values) that the top level muxes onto wifi_en, wifi_gpio0/2/4/12/13.

Parameters:
C_en_low_cycles, 2500000, cycles EN is held low (100 ms at 25 MHz); minimum 1.
C_strap_setup_cycles, 1250000, cycles straps stay driven after EN release, before the release timeout starts; minimum 1.
C_release_timeout, 26, straps are held a further 2^C_release_timeout cycles after setup, then released (about 2.7 s).

Ports:
clk_25mhz  in  1  system clock
rstn  in  1  synchronous active-low reset
req  in  1  start request, sampled each cycle (level or pulse)
req_mode  in  1  sampled with req: 1 = download (GPIO0/GPIO2 low), 0 = normal boot
hold  in  1  force ESP32 in reset (e.g. button); EN low while 1
en_oe  out  1  1 = drive wifi_en low; 0 = float (EN is never driven high)
strap_oe  out  1  1 = drive strap pins with strap_o; 0 = all strap pins Z
strap_o  out  5  {gpio13, gpio12, gpio4, gpio2, gpio0} drive values
busy  out  1  1 while not IDLE
done  out  1  one-cycle pulse when sequence returns to IDLE
state_o  out  2  current FSM state code, for LEDs and debug

Behaviour:
- All outputs are registered. On rstn=0: state IDLE, counters 0, mode register 0, en_oe=0, strap_oe=0, strap_o=5'b10111, busy=0, done=0.
- Strap values:
  - download: strap_o=5'b10100 (gpio13=1, gpio12=0, gpio4=1, gpio2=0, gpio0=0).
  - normal: strap_o=5'b10111.
  - gpio12 is always 0 and gpio13/gpio4 are always 1.
- FSM states:
  - IDLE (00): straps floating; en_oe=hold.
    - req=1 at edge N: latch req_mode, clear counter, enter RESET. en_oe=1, strap_oe=1 and strap_o valid from N+1.
  - RESET (01): en_oe=1, straps driven.
    - Lasts exactly C_en_low_cycles cycles, then SETUP.
    - While hold=1 the counter is held at 0, so RESET is extended until hold has been 0 for C_en_low_cycles cycles.
  - SETUP (10): en_oe=hold, straps driven.
    - After C_strap_setup_cycles cycles, go to HOLD.
    - If hold=1, return to RESET with the counter cleared.
  - HOLD (11): en_oe=hold, straps driven.
    - After 2^C_release_timeout cycles: IDLE, strap_oe=0, and done=1 for one cycle on the first IDLE cycle.
    - If hold=1, return to RESET.
- Request handling:
  - req in RESET or SETUP is ignored; mode is not re-latched.
  - req in HOLD restarts the sequence: enter RESET, re-latch req_mode, clear counter, no done pulse.
  - req and hold together in IDLE: enter RESET; hold then extends RESET.
- Counter: one shared up-counter, width max(clog2(C_en_low_cycles), clog2(C_strap_setup_cycles), C_release_timeout+1). Cleared on every state entry. Wrap is impossible by construction.
- rstn=0 mid-sequence: immediate return to reset values. EN and straps are released on the next edge, and no done pulse is issued.
- busy=1 exactly while state != IDLE.

Decomposition:
- Package esp32_boot_pkg holds:
  - the state encoding (IDLE/RESET/SETUP/HOLD = 0..3);
  - strap_o bit indices;
  - the strap constants STRAP_DOWNLOAD=5'b10100 and STRAP_NORMAL=5'b10111.
- One sub-module, esp32_delay_counter, handles clear, enable and compare-to-terminal, with an expired flag. The FSM instantiates it once.
- Tristate muxing onto pins stays at top level.

Test Plan (C_en_low_cycles=8, C_strap_setup_cycles=4, C_release_timeout=5):
- Reset release, idle 20 cycles -> en_oe=0, strap_oe=0, busy=0, done never asserted.
- Download request: req=1 with req_mode=1 for 1 cycle at N -> from N+1, en_oe=1 for 8 cycles and strap_o=5'b10100; en_oe=0 at N+9; strap_oe=1 until N+44; done=1 only at N+45; busy=0 at N+45.
- Normal request: req_mode=0 -> same timing, strap_o=5'b10111, gpio12 bit 0 throughout.
- hold asserted 20 cycles in the middle of RESET -> en_oe stays 1; RESET ends 8 cycles after hold falls. hold asserted during HOLD -> returns to RESET, full sequence repeats, done only at the end.
- req(mode=0) during RESET is ignored and the mode stays download; req(mode=0) during HOLD restarts with strap_o=5'b10111 and no done pulse at the restart.
- rstn=0 for 1 cycle during SETUP -> next cycle en_oe=0, strap_oe=0, busy=0, done=0, state_o=00.

Source files
------------

// File: rtl/esp32_boot_pkg.sv
// Shared definitions for the ESP32 boot sequencer.
// - FSM state encoding. The same 2-bit code is exported on state_o for LEDs and debug.
// - Bit positions of the strap pins inside strap_o.
// - Strap drive patterns for download mode and normal boot.
// - A small helper that sizes the shared delay counter.
package esp32_boot_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReset = 2'd1,
        StSetup = 2'd2,
        StHold  = 2'd3
    } boot_state_e;

    // strap_o = {gpio13, gpio12, gpio4, gpio2, gpio0}
    localparam int unsigned StrapGpio0  = 0;
    localparam int unsigned StrapGpio2  = 1;
    localparam int unsigned StrapGpio4  = 2;
    localparam int unsigned StrapGpio12 = 3;
    localparam int unsigned StrapGpio13 = 4;

    // gpio12 must stay low (flash voltage); gpio13/gpio4 stay high in both modes.
    localparam logic [4:0] STRAP_DOWNLOAD = 5'b10100;
    localparam logic [4:0] STRAP_NORMAL   = 5'b10111;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/esp32_delay_counter.sv
// Shared up-counter for the boot sequencer phase timing.
// Ports:
//   clk_i     - clock
//   rst_ni    - synchronous active-low reset
//   clear_i   - force the count to zero on the next edge (has priority over en_i)
//   en_i      - increment the count
//   term_i    - terminal count of the current phase
//   expired_o - high while the count equals term_i
module esp32_delay_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == term_i);

endmodule

// File: rtl/esp32_boot_sequencer.sv
// Drives the ESP32 into download mode or normal boot with a timed EN/strap sequence.
// It replaces host DTR/RTS toggling.
// Ports:
//   clk_25mhz - system clock
//   rstn      - synchronous active-low reset
//   req       - start request (level or pulse)
//   req_mode  - sampled with req: 1 = download, 0 = normal boot
//   hold      - keep the ESP32 in reset while high
//   en_oe     - 1 = pull wifi_en low; 0 = float
//   strap_oe  - 1 = drive strap pins with strap_o; 0 = strap pins Z
//   strap_o   - {gpio13, gpio12, gpio4, gpio2, gpio0} drive values
//   busy      - high while not idle
//   done      - one-cycle pulse on the first idle cycle after a completed sequence
//   state_o   - current state code
// Every output is registered from next-state values. An output therefore reflects the
// state entered on the same edge.
module esp32_boot_sequencer
    import esp32_boot_pkg::*;
#(
    parameter int unsigned C_en_low_cycles      = 2500000,
    parameter int unsigned C_strap_setup_cycles = 1250000,
    parameter int unsigned C_release_timeout    = 26
) (
    input  logic       clk_25mhz,
    input  logic       rstn,
    input  logic       req,
    input  logic       req_mode,
    input  logic       hold,
    output logic       en_oe,
    output logic       strap_oe,
    output logic [4:0] strap_o,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_o
);

    localparam int unsigned CntW = max3($clog2(C_en_low_cycles), $clog2(C_strap_setup_cycles),
                                        C_release_timeout + 1);

    // Terminal counts are "cycles - 1" because the counter starts at 0 on state entry.
    localparam logic [CntW-1:0] TermReset = CntW'(C_en_low_cycles - 1);
    localparam logic [CntW-1:0] TermSetup = CntW'(C_strap_setup_cycles - 1);
    localparam logic [CntW-1:0] TermHold  = CntW'((64'd1 << C_release_timeout) - 64'd1);

    boot_state_e     state_q, state_d;
    logic            mode_q, mode_d;
    logic            en_oe_q, en_oe_d;
    logic            strap_oe_q, strap_oe_d;
    logic [4:0]      strap_q, strap_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cnt_clear, cnt_en, cnt_expired;
    logic [CntW-1:0] cnt_term;

    esp32_delay_counter #(
        .Width (CntW)
    ) u_delay_counter (
        .clk_i     (clk_25mhz),
        .rst_ni    (rstn),
        .clear_i   (cnt_clear),
        .en_i      (cnt_en),
        .term_i    (cnt_term),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StReset;
                    mode_d  = req_mode;
                end
            end
            StReset: begin
                if (!hold && cnt_expired) begin
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (hold) begin
                    state_d = StReset;
                end else if (cnt_expired) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                // A new request restarts the sequence and re-latches the mode.
                if (req) begin
                    state_d = StReset;
                    mode_d  = req_mode;
                end else if (hold) begin
                    state_d = StReset;
                end else if (cnt_expired) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_term = TermReset;
        unique case (state_q)
            StSetup: cnt_term = TermSetup;
            StHold:  cnt_term = TermHold;
            default: cnt_term = TermReset;
        endcase
    end

    // Clear the counter on every state change. Also clear it while hold pins RESET, so the
    // EN-low time restarts from the falling edge of hold.
    assign cnt_en    = (state_q != StIdle);
    assign cnt_clear = (state_d != state_q) || (state_q == StIdle)
                    || ((state_q == StReset) && hold);

    always_comb begin
        en_oe_d    = (state_d == StReset) || hold;
        strap_oe_d = (state_d != StIdle);
        strap_d    = (strap_oe_d && mode_d) ? STRAP_DOWNLOAD : STRAP_NORMAL;
        busy_d     = (state_d != StIdle);
        done_d     = (state_q == StHold) && (state_d == StIdle);
    end

    always_ff @(posedge clk_25mhz) begin
        if (!rstn) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            en_oe_q    <= 1'b0;
            strap_oe_q <= 1'b0;
            strap_q    <= STRAP_NORMAL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            en_oe_q    <= en_oe_d;
            strap_oe_q <= strap_oe_d;
            strap_q    <= strap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign en_oe    = en_oe_q;
    assign strap_oe = strap_oe_q;
    assign strap_o  = strap_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Bench for esp32_boot_sequencer with short timing: EN low 8, setup 4, release 2^5.
// It has two parts. A vector table covers the directed scenarios. A randomized run is
// then checked against a position-in-sequence reference model.
module tb_esp32_boot_sequencer;

    localparam int unsigned EnLow  = 8;
    localparam int unsigned SetupN = 4;
    localparam int unsigned Rt     = 5;
    localparam int          SeqLen = EnLow + SetupN + (1 << Rt);  // 44 driven cycles
    localparam logic [4:0]  SD     = 5'b10100;
    localparam logic [4:0]  SN     = 5'b10111;

    logic       clk = 1'b0;
    logic       rstn, req, req_mode, hold;
    logic       en_oe, strap_oe, busy, done;
    logic [4:0] strap_o;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    esp32_boot_sequencer #(
        .C_en_low_cycles      (EnLow),
        .C_strap_setup_cycles (SetupN),
        .C_release_timeout    (Rt)
    ) dut (
        .clk_25mhz (clk),
        .rstn      (rstn),
        .req       (req),
        .req_mode  (req_mode),
        .hold      (hold),
        .en_oe     (en_oe),
        .strap_oe  (strap_oe),
        .strap_o   (strap_o),
        .busy      (busy),
        .done      (done),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // Inputs are held for n cycles. req is raised only on the first of those cycles.
    // The expected outputs are checked after the n-th rising edge.
    typedef struct {
        logic       rstn;
        logic       req;
        logic       mode;
        logic       hold;
        int         n;
        logic       en;
        logic       soe;
        logic [4:0] strap;
        logic       busy;
        logic       done;
        logic [1:0] st;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic q, logic m, logic h, int n,
                                logic en, logic soe, logic [4:0] s, logic b, logic d,
                                logic [1:0] st);
        vec_t v;
        v.name = name; v.rstn = r; v.req = q; v.mode = m; v.hold = h; v.n = n;
        v.en = en; v.soe = soe; v.strap = s; v.busy = b; v.done = d; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full sequence with no interference, for the given mode.
    task automatic add_full(input string tag, input logic m, input logic [4:0] s);
        vecs.push_back(mk({tag, "_start"}, 1, 1, m, 0, 1, 1, 1, s, 1, 0, 2'd1));
        vecs.push_back(mk({tag, "_rst_end"}, 1, 0, 0, 0, EnLow - 1, 1, 1, s, 1, 0, 2'd1));
        vecs.push_back(mk({tag, "_setup0"}, 1, 0, 0, 0, 1, 0, 1, s, 1, 0, 2'd2));
        vecs.push_back(mk({tag, "_setup_end"}, 1, 0, 0, 0, SetupN - 1, 0, 1, s, 1, 0, 2'd2));
        vecs.push_back(mk({tag, "_hold0"}, 1, 0, 0, 0, 1, 0, 1, s, 1, 0, 2'd3));
        vecs.push_back(mk({tag, "_hold_end"}, 1, 0, 0, 0, (1 << Rt) - 1, 0, 1, s, 1, 0, 2'd3));
        vecs.push_back(mk({tag, "_done"}, 1, 0, 0, 0, 1, 0, 0, s, 0, 1, 2'd0));
        vecs.push_back(mk({tag, "_idle"}, 1, 0, 0, 0, 1, 0, 0, s, 0, 0, 2'd0));
    endtask

    task automatic build_table();
        vecs.push_back(mk("reset", 0, 0, 0, 0, 2, 0, 0, SN, 0, 0, 2'd0));
        vecs.push_back(mk("idle20", 1, 0, 0, 0, 20, 0, 0, SN, 0, 0, 2'd0));
        add_full("dl", 1'b1, SD);
        add_full("nb", 1'b0, SN);
        // hold in the middle of RESET, then hold during HOLD.
        vecs.push_back(mk("hr_start", 1, 1, 1, 0, 1, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("hr_pre", 1, 0, 0, 0, 3, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("hr_hold20", 1, 0, 0, 1, 20, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("hr_ext", 1, 0, 0, 0, EnLow - 1, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("hr_setup", 1, 0, 0, 0, 1, 0, 1, SD, 1, 0, 2'd2));
        vecs.push_back(mk("hr_hold", 1, 0, 0, 0, SetupN, 0, 1, SD, 1, 0, 2'd3));
        vecs.push_back(mk("hh_back", 1, 0, 0, 1, 1, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("hh_rst_end", 1, 0, 0, 0, EnLow - 1, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("hh_setup", 1, 0, 0, 0, 1, 0, 1, SD, 1, 0, 2'd2));
        vecs.push_back(mk("hh_hold", 1, 0, 0, 0, SetupN, 0, 1, SD, 1, 0, 2'd3));
        vecs.push_back(mk("hh_hold_end", 1, 0, 0, 0, (1 << Rt) - 1, 0, 1, SD, 1, 0, 2'd3));
        vecs.push_back(mk("hh_done", 1, 0, 0, 0, 1, 0, 0, SD, 0, 1, 2'd0));
        // req during RESET is ignored; req during HOLD restarts with the new mode.
        vecs.push_back(mk("rq_start", 1, 1, 1, 0, 1, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("rq_ignored", 1, 1, 0, 0, 1, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("rq_setup", 1, 0, 0, 0, 10, 0, 1, SD, 1, 0, 2'd2));
        vecs.push_back(mk("rq_hold", 1, 0, 0, 0, 6, 0, 1, SD, 1, 0, 2'd3));
        vecs.push_back(mk("rq_restart", 1, 1, 0, 0, 1, 1, 1, SN, 1, 0, 2'd1));
        vecs.push_back(mk("rq_hold_end", 1, 0, 0, 0, SeqLen - 1, 0, 1, SN, 1, 0, 2'd3));
        vecs.push_back(mk("rq_done", 1, 0, 0, 0, 1, 0, 0, SN, 0, 1, 2'd0));
        // rstn pulse during SETUP.
        vecs.push_back(mk("rs_start", 1, 1, 1, 0, 1, 1, 1, SD, 1, 0, 2'd1));
        vecs.push_back(mk("rs_setup", 1, 0, 0, 0, EnLow + 1, 0, 1, SD, 1, 0, 2'd2));
        vecs.push_back(mk("rs_reset", 0, 0, 0, 0, 1, 0, 0, SN, 0, 0, 2'd0));
        vecs.push_back(mk("rs_idle", 1, 0, 0, 0, 1, 0, 0, SN, 0, 0, 2'd0));
        // req with hold in IDLE; hold then extends RESET. In IDLE, en_oe follows hold.
        vecs.push_back(mk("rh_start", 1, 1, 0, 1, 1, 1, 1, SN, 1, 0, 2'd1));
        vecs.push_back(mk("rh_held", 1, 0, 0, 1, 5, 1, 1, SN, 1, 0, 2'd1));
        vecs.push_back(mk("rh_rst_end", 1, 0, 0, 0, EnLow - 1, 1, 1, SN, 1, 0, 2'd1));
        vecs.push_back(mk("rh_setup", 1, 0, 0, 0, 1, 0, 1, SN, 1, 0, 2'd2));
        vecs.push_back(mk("rh_clear", 0, 0, 0, 0, 1, 0, 0, SN, 0, 0, 2'd0));
        vecs.push_back(mk("ih_en", 1, 0, 0, 1, 2, 1, 0, SN, 0, 0, 2'd0));
        vecs.push_back(mk("ih_release", 1, 0, 0, 0, 1, 0, 0, SN, 0, 0, 2'd0));
    endtask

    // Reference model: a sequence is a run of SeqLen driven cycles, indexed by position.
    // Positions 0..EnLow-1 are EN low. The next SetupN positions are the setup window.
    // The rest is the release timeout. hold sends the position back to 0.
    bit m_act, m_mode, m_done;
    int m_pos;
    bit m_en;

    task automatic model_step(input bit r, input bit q, input bit m, input bit h);
        if (!r) begin
            m_act = 0; m_mode = 0; m_done = 0; m_pos = 0; m_en = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (q) begin
                    m_act = 1; m_pos = 0; m_mode = m;
                end
            end else if (q && m_pos >= int'(EnLow + SetupN)) begin
                m_pos = 0; m_mode = m;
            end else if (h) begin
                m_pos = 0;
            end else if (m_pos == SeqLen - 1) begin
                m_act = 0; m_done = 1;
            end else begin
                m_pos++;
            end
            m_en = m_act ? (m_pos < int'(EnLow)) : h;
        end
    endtask

    function automatic logic [1:0] model_state();
        if (!m_act) return 2'd0;
        if (m_pos < int'(EnLow)) return 2'd1;
        if (m_pos < int'(EnLow + SetupN)) return 2'd2;
        return 2'd3;
    endfunction

    initial begin
        int hold_left;
        logic [1:0] exp_st;
        rstn = 1'b0; req = 1'b0; req_mode = 1'b0; hold = 1'b0;
        build_table();

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                rstn     = vecs[i].rstn;
                req      = (c == 0) ? vecs[i].req : 1'b0;
                req_mode = vecs[i].mode;
                hold     = vecs[i].hold;
                @(posedge clk);
                #1;
                if (c != vecs[i].n - 1) chk({vecs[i].name, "_done_mid"}, done, 0);
            end
            chk({vecs[i].name, "_en"}, en_oe, vecs[i].en);
            chk({vecs[i].name, "_soe"}, strap_oe, vecs[i].soe);
            if (vecs[i].soe || !vecs[i].rstn) chk({vecs[i].name, "_strap"}, strap_o, vecs[i].strap);
            chk({vecs[i].name, "_busy"}, busy, vecs[i].busy);
            chk({vecs[i].name, "_done"}, done, vecs[i].done);
            chk({vecs[i].name, "_state"}, state_o, vecs[i].st);
        end

        hold_left = 0;
        for (int c = 0; c < 4000; c++) begin
            rstn     = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            req      = ($urandom_range(0, 59) == 0);
            req_mode = $urandom_range(0, 1) == 1;
            if (hold_left > 0) begin
                hold = 1'b1;
                hold_left--;
            end else if ($urandom_range(0, 119) == 0) begin
                hold = 1'b1;
                hold_left = $urandom_range(0, 11);
            end else begin
                hold = 1'b0;
            end
            @(posedge clk);
            model_step(rstn, req, req_mode, hold);
            #1;
            exp_st = model_state();
            chk("rnd_en", en_oe, m_en);
            chk("rnd_soe", strap_oe, m_act);
            if (m_act) chk("rnd_strap", strap_o, m_mode ? SD : SN);
            chk("rnd_busy", busy, m_act);
            chk("rnd_done", done, m_done);
            chk("rnd_state", state_o, exp_st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
